vga_timing_gen: RTL



---
 rtl/vga_pkg.sv | 30 +++
 rtl/sig_delay_line.sv | 35 +++
 rtl/vga_timing_gen.sv | 104 ++++++++++
 3 files changed

// File: rtl/vga_pkg.sv
// 640x480@60 raster timing constants shared by the VGA path.
// DEF_* are the defaults; the derived totals and sync windows follow from them.
package vga_pkg;

  localparam int DEF_CLK_DIV  = 4;
  localparam int DEF_H_DISP   = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_DISP   = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;
  localparam int DEF_PIPE_DLY = 1;

  localparam int H_TOTAL      = DEF_H_DISP + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int V_TOTAL      = DEF_V_DISP + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;
  localparam int H_SYNC_START = DEF_H_DISP + DEF_H_FP;
  localparam int H_SYNC_END   = H_SYNC_START + DEF_H_SYNC;
  localparam int V_SYNC_START = DEF_V_DISP + DEF_V_FP;
  localparam int V_SYNC_END   = V_SYNC_START + DEF_V_SYNC;

  typedef logic [9:0] cnt_t;

  // Half-open window test [lo, hi) on unsigned counter values.
  function automatic logic in_window(cnt_t pos, cnt_t lo, cnt_t hi);
    return (pos >= lo) && (pos < hi);
  endfunction

endpackage

// File: rtl/sig_delay_line.sv
// Async-reset shift register of DEPTH stages; DEPTH=0 is a plain wire.
// Every stage resets to RST_VAL so a reset never leaves a stale pulse in flight.
module sig_delay_line #(
  parameter int               WIDTH   = 1,
  parameter int               DEPTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] delayed
);

  generate
    if (DEPTH == 0) begin : g_pass
      logic unused_clk_rst;
      assign unused_clk_rst = clk ^ rst_n;
      assign delayed = data;
    end else begin : g_shift
      logic [WIDTH-1:0] stage [DEPTH];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < DEPTH; i++) stage[i] <= RST_VAL;
        end else begin
          stage[0] <= data;
          for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
        end
      end

      assign delayed = stage[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// Raster scan generator: pixel-rate tick, h/v counters, frame_start, and
// active-low syncs plus visible flag delayed PIPE_DLY clks to match BRAM latency.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int CLK_DIV  = DEF_CLK_DIV,
  parameter int H_DISP   = DEF_H_DISP,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_DISP   = DEF_V_DISP,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter int PIPE_DLY = DEF_PIPE_DLY
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic       pix_tick,
  output logic [9:0] h_cnt,
  output logic [9:0] v_cnt,
  output logic       frame_start,
  output logic       hsync,
  output logic       vsync,
  output logic       valid
);

  localparam int LINE_LEN    = H_DISP + H_FP + H_SYNC + H_BP;
  localparam int FRAME_LINES = V_DISP + V_FP + V_SYNC + V_BP;
  localparam int DIV_W       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam cnt_t H_LAST = cnt_t'(LINE_LEN - 1);
  localparam cnt_t V_LAST = cnt_t'(FRAME_LINES - 1);
  localparam cnt_t H_VIS  = cnt_t'(H_DISP);
  localparam cnt_t V_VIS  = cnt_t'(V_DISP);
  localparam cnt_t H_SS   = cnt_t'(H_DISP + H_FP);
  localparam cnt_t H_SE   = cnt_t'(H_DISP + H_FP + H_SYNC);
  localparam cnt_t V_SS   = cnt_t'(V_DISP + V_FP);
  localparam cnt_t V_SE   = cnt_t'(V_DISP + V_FP + V_SYNC);

  generate
    if (LINE_LEN > 1024 || FRAME_LINES > 1024 || CLK_DIV < 1 || CLK_DIV > 16 ||
        PIPE_DLY < 0 || PIPE_DLY > 3) begin : g_bad_cfg
      $error("vga_timing_gen: timing does not fit 10-bit counters or parameter out of range");
    end
  endgenerate

  logic [DIV_W-1:0] div_cnt;
  logic             tick;
  cnt_t             h_nxt;
  cnt_t             v_nxt;
  logic             hsync_raw;
  logic             vsync_raw;
  logic             valid_raw;

  always_comb begin
    tick  = (div_cnt == DIV_LAST);
    h_nxt = h_cnt;
    v_nxt = v_cnt;
    if (tick) begin
      h_nxt = (h_cnt == H_LAST) ? '0 : h_cnt + 10'd1;
      if (h_cnt == H_LAST) begin
        v_nxt = (v_cnt == V_LAST) ? '0 : v_cnt + 10'd1;
      end
    end
  end

  // Raw sync/valid come from the next-state counters so they switch with h_cnt/v_cnt.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt     <= '0;
      pix_tick    <= 1'b0;
      frame_start <= 1'b0;
      h_cnt       <= H_LAST;
      v_cnt       <= V_LAST;
      hsync_raw   <= 1'b1;
      vsync_raw   <= 1'b1;
      valid_raw   <= 1'b0;
    end else begin
      div_cnt     <= tick ? '0 : div_cnt + DIV_W'(1);
      pix_tick    <= tick;
      frame_start <= tick && (h_nxt == '0) && (v_nxt == '0);
      h_cnt       <= h_nxt;
      v_cnt       <= v_nxt;
      hsync_raw   <= !in_window(h_nxt, H_SS, H_SE);
      vsync_raw   <= !in_window(v_nxt, V_SS, V_SE);
      valid_raw   <= (h_nxt < H_VIS) && (v_nxt < V_VIS);
    end
  end

  sig_delay_line #(.WIDTH(1), .DEPTH(PIPE_DLY), .RST_VAL(1'b1)) u_hsync_dly (
    .clk(clk), .rst_n(rst_n), .data(hsync_raw), .delayed(hsync)
  );

  sig_delay_line #(.WIDTH(1), .DEPTH(PIPE_DLY), .RST_VAL(1'b1)) u_vsync_dly (
    .clk(clk), .rst_n(rst_n), .data(vsync_raw), .delayed(vsync)
  );

  sig_delay_line #(.WIDTH(1), .DEPTH(PIPE_DLY), .RST_VAL(1'b0)) u_valid_dly (
    .clk(clk), .rst_n(rst_n), .data(valid_raw), .delayed(valid)
  );

endmodule
